// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART-to-register bridge.
package uart_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WDATA   = 3'd1,
      WCOMMIT = 3'd2,
      RREQ    = 3'd3,
      RCAPT   = 3'd4,
      TXLOAD  = 3'd5,
      TXWAIT  = 3'd6
   } bridge_state_t;

   localparam int         CMD_READ_BIT = 7;
   localparam logic [7:0] ACK_OK       = 8'hA5;
   localparam logic [7:0] ACK_ERR      = 8'hEE;

   function automatic int calc_nb(input int data_w);
      return (data_w + 7) / 8;
   endfunction

endpackage

// File: rtl/uart_bridge_timeout.sv
// Inter-byte timeout: down-counter reloaded on every received byte; pulses
// expired when it runs out while enabled.
module uart_bridge_timeout #(
   parameter int TIMEOUT_CYC = 5_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic reload,
   output logic expired
);

   localparam int            CW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset_n)
         cnt <= '0;
      else if (reload)
         cnt <= LOAD_VAL;
      else if (en && cnt != '0)
         cnt <= cnt - CW'(1);
   end

   // A byte arriving in the expiry cycle wins over the timeout.
   assign expired = en && !reload && (cnt == '0);

endmodule

// File: rtl/uart_reg_bridge.sv
// UART byte stream to register bus bridge (write/read frames, read response).
// Optional UART_BRIDGE_ACK_EN: send an ack byte after every committed write frame.
//
// state   | meaning
// IDLE    | waiting for a command byte
// WDATA   | collecting NB write data bytes, MSB first
// WCOMMIT | issue reg_we (or frame_err on bad address)
// RREQ    | issue reg_re (or frame_err on bad address)
// RCAPT   | capture reg_rdata into the tx shift register
// TXLOAD  | wait for transmitter idle, then start next byte
// TXWAIT  | skip one cycle of start latency, then wait for transmitter idle
module uart_reg_bridge
   import uart_bridge_pkg::*;
#(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 12,
   parameter int TIMEOUT_CYC = 5_000_000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   output logic              reg_we,
   output logic              reg_re,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              bridge_busy,
   output logic              frame_err
);

   localparam int NB = calc_nb(DATA_W);
   localparam int SW = NB * 8;
   localparam int CW = $clog2(NB + 1);

   bridge_state_t state, state_nxt;

   logic [CW-1:0] bcnt;
   logic [SW-1:0] wsh;
   logic [SW-1:0] tsh;
   logic [SW-1:0] wsh_next;
   logic          bad_addr;
   logic          bad_cmd;
   logic          tx_first;
   logic          tmo_exp;
   logic          overrun;

   assign wsh_next = (wsh << 8) | SW'(rx_data);
   assign bad_cmd  = (rx_data[6:0] >> ADDR_W) != 7'd0;
   assign tx_data  = tsh[SW-1 -: 8];

   uart_bridge_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (state == WDATA),
      .reload  (rx_valid),
      .expired (tmo_exp)
   );

   always_ff @(posedge clk) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rx_valid) state_nxt = rx_data[CMD_READ_BIT] ? RREQ : WDATA;
         WDATA: begin
            if (bcnt == '0)
               state_nxt = WCOMMIT;
            else if (tmo_exp)
               state_nxt = IDLE;
         end
`ifdef UART_BRIDGE_ACK_EN
         WCOMMIT: state_nxt = TXLOAD;
`else
         WCOMMIT: state_nxt = IDLE;
`endif
         RREQ:    state_nxt = RCAPT;
         RCAPT:   state_nxt = TXLOAD;
         TXLOAD:  if (!tx_busy) state_nxt = TXWAIT;
         TXWAIT:  if (!tx_first && !tx_busy) state_nxt = (bcnt != '0) ? TXLOAD : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The cycle after the last data byte (bcnt == 0) is the commit slot, so
   // a byte landing there is treated as an overrun rather than shifted in.
   always_comb begin
      overrun     = rx_valid && !(state == IDLE || (state == WDATA && bcnt != '0));
      reg_we      = (state == WCOMMIT) && !bad_addr;
      reg_re      = (state == RREQ) && !bad_addr;
      tx_start    = (state == TXLOAD) && !tx_busy;
      bridge_busy = (state != IDLE);
      frame_err   = overrun || tmo_exp ||
                    ((state == WCOMMIT || state == RREQ) && bad_addr);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         reg_addr  <= '0;
         reg_wdata <= '0;
         wsh       <= '0;
         tsh       <= '0;
         bcnt      <= '0;
         bad_addr  <= 1'b0;
         tx_first  <= 1'b0;
      end else begin
         tx_first <= 1'b0;
         case (state)
            IDLE: begin
               if (rx_valid) begin
                  reg_addr <= rx_data[ADDR_W-1:0];
                  bad_addr <= bad_cmd;
                  bcnt     <= CW'(NB);
                  wsh      <= '0;
               end
            end
            WDATA: begin
               if (rx_valid && bcnt != '0) begin
                  wsh  <= wsh_next;
                  bcnt <= bcnt - CW'(1);
                  if (bcnt == CW'(1))
                     reg_wdata <= wsh_next[DATA_W-1:0];
               end
            end
`ifdef UART_BRIDGE_ACK_EN
            WCOMMIT: begin
               tsh  <= SW'(bad_addr ? ACK_ERR : ACK_OK) << (SW - 8);
               bcnt <= CW'(1);
            end
`endif
            RCAPT: begin
               tsh  <= bad_addr ? '0 : SW'(reg_rdata);
               bcnt <= CW'(NB);
            end
            TXLOAD: begin
               if (!tx_busy) begin
                  tsh      <= tsh << 8;
                  bcnt     <= bcnt - CW'(1);
                  tx_first <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Scoreboard bench for uart_reg_bridge: expected writes, reads, tx bytes and
// frame errors are queued by the stimulus and consumed by a negedge monitor.
module tb_uart_reg_bridge;

   localparam int ADDR_W   = 4;
   localparam int DATA_W   = 12;
   localparam int TMO      = 100;
   localparam int BUSY_LEN = 6;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              tx_busy = 1'b0;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic              reg_we;
   logic              reg_re;
   logic [ADDR_W-1:0] reg_addr;
   logic [DATA_W-1:0] reg_wdata;
   logic [DATA_W-1:0] reg_rdata = '1;
   logic              bridge_busy;
   logic              frame_err;

   uart_reg_bridge #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .tx_busy     (tx_busy),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .reg_we      (reg_we),
      .reg_re      (reg_re),
      .reg_addr    (reg_addr),
      .reg_wdata   (reg_wdata),
      .reg_rdata   (reg_rdata),
      .bridge_busy (bridge_busy),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t               exp_wr[$];
   logic [ADDR_W-1:0] exp_rd[$];
   logic [7:0]        exp_tx[$];

   int n_checks = 0;
   int n_fail   = 0;
   int err_cnt  = 0;
   int exp_err  = 0;
   int err_cyc  = 0;
   int last_rx_cyc = 0;
   logic [DATA_W-1:0] rd_val = '0;
   int rd_hold  = 0;
   int busy_cnt = 0;
   bit start_d  = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Monitor, register read model and transmitter model, all on the negedge.
   initial begin
      wr_t               e;
      logic [ADDR_W-1:0] a;
      logic [7:0]        b;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (reg_we) begin
               if (exp_wr.size() == 0) check_val("unexpected_we", 1, 0);
               else begin
                  e = exp_wr.pop_front();
                  check_val("we_addr", 32'(reg_addr), 32'(e.addr));
                  check_val("we_data", 32'(reg_wdata), 32'(e.data));
                  check_val("we_latency", cyc - last_rx_cyc, 2);
               end
            end
            if (reg_re) begin
               if (exp_rd.size() == 0) check_val("unexpected_re", 1, 0);
               else begin
                  a = exp_rd.pop_front();
                  check_val("re_addr", 32'(reg_addr), 32'(a));
               end
            end
            if (tx_start) begin
               check_val("tx_busy_at_start", 32'(tx_busy), 0);
               if (exp_tx.size() == 0) check_val("unexpected_tx_start", 1, 0);
               else begin
                  b = exp_tx.pop_front();
                  check_val("tx_data", 32'(tx_data), 32'(b));
               end
            end
            if (frame_err) begin
               err_cnt++;
               err_cyc = cyc;
            end
         end
         if (reg_re) begin
            reg_rdata = rd_val;
            rd_hold   = 2;
         end else if (rd_hold > 0) begin
            rd_hold--;
            if (rd_hold == 0) reg_rdata = '1;
         end
         if (busy_cnt > 0) busy_cnt--;
         if (start_d) busy_cnt = BUSY_LEN;
         tx_busy = (busy_cnt > 0);
         start_d = tx_start && reset_n;
      end
   end

   task automatic send_byte(input logic [7:0] v);
      @(posedge clk); #1;
      rx_valid    = 1'b1;
      rx_data     = v;
      last_rx_cyc = cyc;
      @(posedge clk); #1;
      rx_valid    = 1'b0;
   endtask

   task automatic settle(input int max_cyc);
      int n;
      n = 0;
      while ((bridge_busy || tx_busy || exp_tx.size() != 0 || exp_wr.size() != 0 ||
              exp_rd.size() != 0) && n < max_cyc) begin
         @(posedge clk);
         n++;
      end
      if (n >= max_cyc) check_val("settle_timeout", n, 0);
      repeat (3) @(posedge clk);
      #1;
      check_val("frame_err_cnt", err_cnt, exp_err);
   endtask

   task automatic wait_first_tx(input int max_cyc);
      int n;
      n = 0;
      while (exp_tx.size() > 1 && n < max_cyc) begin
         @(posedge clk);
         n++;
      end
      if (n >= max_cyc) check_val("first_tx_timeout", n, 0);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check_val({tag, "_tx_start"},  32'(tx_start), 0);
      check_val({tag, "_tx_data"},   32'(tx_data), 0);
      check_val({tag, "_reg_we"},    32'(reg_we), 0);
      check_val({tag, "_reg_re"},    32'(reg_re), 0);
      check_val({tag, "_reg_addr"},  32'(reg_addr), 0);
      check_val({tag, "_reg_wdata"}, 32'(reg_wdata), 0);
      check_val({tag, "_busy"},      32'(bridge_busy), 0);
      check_val({tag, "_frame_err"}, 32'(frame_err), 0);
   endtask

   initial begin
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;
      logic [7:0]        junk;

      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Basic write 0xABC -> address 3.
      exp_wr.push_back('{4'd3, 12'hABC});
`ifdef UART_BRIDGE_ACK_EN
      exp_tx.push_back(8'hA5);
`endif
      send_byte(8'h03); send_byte(8'h0A); send_byte(8'hBC);
      settle(300);

      // Read address 5, data 0x123 -> 0x01, 0x23.
      rd_val = 12'h123;
      exp_rd.push_back(4'd5);
      exp_tx.push_back(8'h01); exp_tx.push_back(8'h23);
      send_byte(8'h85);
      settle(300);

      // Bad-address write and read.
      exp_err++;
`ifdef UART_BRIDGE_ACK_EN
      exp_tx.push_back(8'hEE);
`endif
      send_byte(8'h13); send_byte(8'h01); send_byte(8'h02);
      settle(300);
      exp_err++;
      exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
      send_byte(8'h93);
      settle(300);

      // Timeout after a partial write frame, then a clean frame.
      exp_err++;
      send_byte(8'h02); send_byte(8'h0F);
      settle(400);
      check_val("timeout_latency", err_cyc - last_rx_cyc, TMO);
      exp_wr.push_back('{4'd2, 12'h111});
      send_byte(8'h02); send_byte(8'h01); send_byte(8'h11);
      settle(300);

      // Overrun during a read response leaves the response intact.
      rd_val = 12'h9C4;
      exp_rd.push_back(4'd7);
      exp_tx.push_back(8'h09); exp_tx.push_back(8'hC4);
      send_byte(8'h87);
      wait_first_tx(300);
      exp_err++;
      send_byte(8'h55);
      settle(300);

      // Random writes; junk in the ignored upper bits of the first data byte.
      for (int i = 0; i < 4; i++) begin
         ra   = ADDR_W'($urandom_range(0, 15));
         rd   = DATA_W'($urandom_range(0, 4095));
         junk = 8'($urandom_range(0, 15)) << 4;
         exp_wr.push_back('{ra, rd});
`ifdef UART_BRIDGE_ACK_EN
         exp_tx.push_back(8'hA5);
`endif
         send_byte({4'h0, ra});
         send_byte(junk | {4'h0, rd[11:8]});
         send_byte(rd[7:0]);
         settle(300);
      end

      // Reset in the middle of a read response.
      rd_val = 12'h5A5;
      exp_rd.push_back(4'd1);
      exp_tx.push_back(8'h05); exp_tx.push_back(8'hA5);
      send_byte(8'h81);
      wait_first_tx(300);
      reset_n = 1'b0;
      exp_tx.delete();
      @(posedge clk);
      @(negedge clk);
      check_outputs_zero("midreset");
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check_val("post_reset_busy", 32'(bridge_busy), 0);
      check_val("post_reset_err", err_cnt, exp_err);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not complete (checks=%0d failures=%0d)", n_checks, n_fail);
      $fatal(1);
   end

endmodule
